// File: rtl/lc3b_mem_responder_if.sv
// ---------------------------------------------------------------------------
// lc3b_mem_responder_if
// Memory request/response bundle between an LC-3b initiator and the
// memory responder.
//
// Handshake: the initiator raises mem_read or mem_write with address, data
// and byte mask, and holds them until it sees the one-cycle mem_resp pulse.
// The responder latches the request on the sampling edge, and later inputs
// are ignored. The only exception is that dropping the request line while
// the responder is busy aborts the transaction. mem_rdata is valid with
// mem_resp and is held afterwards. mem_err is a sticky protocol-error flag.
//
// Signals:
//   mem_address     16  byte address, bit 0 ignored
//   mem_wdata       16  write data
//   mem_read         1  read request
//   mem_write        1  write request
//   mem_byte_enable  2  write byte mask (bit0 -> [7:0], bit1 -> [15:8])
//   mem_resp         1  completion pulse
//   mem_rdata       16  read data
//   mem_err          1  sticky read+write-together flag
// ---------------------------------------------------------------------------
interface lc3b_mem_responder_if;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
    input  mem_resp, mem_rdata, mem_err
  );

  modport slave (
    input  mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
    output mem_resp, mem_rdata, mem_err
  );
endinterface

// File: rtl/lc3b_mem_responder.sv
// ---------------------------------------------------------------------------
// lc3b_mem_responder
// Word-addressed memory that answers LC-3b mem_read/mem_write requests. It
// serves one request at a time and raises mem_resp LATENCY cycles after the
// request's first cycle.
//
// Parameters:
//   LATENCY    1..15  cycles from request to mem_resp
//   ADDR_BITS         log2 depth in 16-bit words
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   bus               lc3b_mem_responder_if.slave
//   o_dbg_state       current FSM state (IDLE=0, BUSY=1, RESP=2)
//   read_count,       saturating completed-op counters, present only when
//   write_count       LC3B_MEM_RESPONDER_STATS_EN is defined
// ---------------------------------------------------------------------------
module lc3b_mem_responder #(
  parameter int LATENCY   = 3,
  parameter int ADDR_BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  lc3b_mem_responder_if.slave         bus,
  output logic [1:0]                  o_dbg_state
`ifdef LC3B_MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0]                 read_count,
  output logic [15:0]                 write_count
`endif
);

  localparam int        DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                 r_state, w_next;
  logic [3:0]             r_cnt, w_cnt_next;
  logic                   r_rd, r_wr;
  logic [ADDR_BITS-1:0]   r_idx;
  logic [15:0]            r_wdata;
  logic [1:0]             r_mask;
  logic                   r_resp;
  logic [15:0]            r_rdata;
  logic                   r_err;
  logic [15:0]            r_mem [DEPTH];

  logic                   w_req;
  logic                   w_hold;
  logic                   w_enter_resp;
  logic                   w_from_idle;
  logic                   w_op_rd, w_op_wr;
  logic [ADDR_BITS-1:0]   w_op_idx;
  logic [15:0]            w_op_wdata;
  logic [1:0]             w_op_mask;
  logic                   w_unused_addr;

  assign w_req         = bus.mem_read | bus.mem_write;
  // A transaction stays alive only while the request line it was accepted on
  // is still high.
  assign w_hold        = (r_rd & bus.mem_read) | (r_wr & bus.mem_write);
  assign w_unused_addr = ^{bus.mem_address[15:ADDR_BITS+1], bus.mem_address[0]};

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (LATENCY > 1) begin
            w_next     = ST_BUSY;
            w_cnt_next = CNT_INIT;
          end else begin
            w_next = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        if (!w_hold) begin
          w_next     = ST_IDLE;
          w_cnt_next = 4'd0;
        end else if (r_cnt == 4'd0) begin
          w_next = ST_RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_enter_resp = (w_next == ST_RESP);

  // With LATENCY == 1 the request enters RESP straight from IDLE, so the
  // commit has to use the live inputs rather than the latched copy.
  assign w_from_idle = (r_state == ST_IDLE);
  assign w_op_rd     = w_from_idle ? bus.mem_read                       : r_rd;
  assign w_op_wr     = w_from_idle ? bus.mem_write                      : r_wr;
  assign w_op_idx    = w_from_idle ? bus.mem_address[ADDR_BITS:1]       : r_idx;
  assign w_op_wdata  = w_from_idle ? bus.mem_wdata                      : r_wdata;
  assign w_op_mask   = w_from_idle ? bus.mem_byte_enable                : r_mask;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 16'h0000;
      r_mask  <= 2'b00;
      r_resp  <= 1'b0;
      r_rdata <= 16'h0000;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_resp  <= w_enter_resp;
      r_err   <= r_err | (bus.mem_read & bus.mem_write);
      if (w_from_idle && w_req) begin
        r_rd    <= bus.mem_read;
        r_wr    <= bus.mem_write;
        r_idx   <= bus.mem_address[ADDR_BITS:1];
        r_wdata <= bus.mem_wdata;
        r_mask  <= bus.mem_byte_enable;
      end
      // A simultaneous read+write is treated as a write; rdata is left alone.
      if (w_enter_resp && w_op_rd && !w_op_wr) begin
        r_rdata <= r_mem[w_op_idx];
      end
    end
  end

  // Array contents survive reset; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (rst_n && w_enter_resp && w_op_wr) begin
      if (w_op_mask[0]) r_mem[w_op_idx][7:0]  <= w_op_wdata[7:0];
      if (w_op_mask[1]) r_mem[w_op_idx][15:8] <= w_op_wdata[15:8];
    end
  end

`ifdef LC3B_MEM_RESPONDER_STATS_EN
  logic [15:0] r_read_count, r_write_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_read_count  <= 16'h0000;
      r_write_count <= 16'h0000;
    end else if (w_enter_resp) begin
      if (w_op_wr) begin
        if (r_write_count != 16'hFFFF) r_write_count <= r_write_count + 16'd1;
      end else if (w_op_rd) begin
        if (r_read_count != 16'hFFFF) r_read_count <= r_read_count + 16'd1;
      end
    end
  end

  assign read_count  = r_read_count;
  assign write_count = r_write_count;
`endif

  assign bus.mem_resp  = r_resp;
  assign bus.mem_rdata = r_rdata;
  assign bus.mem_err   = r_err;
  assign o_dbg_state   = r_state;

endmodule
